// File: rtl/vr_reg_slice.sv
// Valid/ready register slice: MODE 0 forward, 1 backward (skid), 2 fully registered.
// Optional synchronous flush input when VR_REG_SLICE_FLUSH_EN is defined.
module vr_reg_slice #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MODE  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m_valid,
    input  logic [WIDTH-1:0] m_data,
    output logic             m_ready,
    output logic             s_valid,
    output logic [WIDTH-1:0] s_data,
    input  logic             s_ready,
`ifdef VR_REG_SLICE_FLUSH_EN
    input  logic             flush,
`endif
    output logic [1:0]       level
);

    logic flush_c;
    logic block_c;

`ifdef VR_REG_SLICE_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // Reset and flush both refuse new master beats in the same cycle.
    assign block_c = rst | flush_c;

    if (MODE == 0) begin : g_fwd
        logic             valid_q, valid_d;
        logic [WIDTH-1:0] data_q, data_d;
        logic             accept_c;

        assign m_ready  = ~block_c & (~valid_q | s_ready);
        assign accept_c = m_valid & m_ready;

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (accept_c) begin
                valid_d = 1'b1;
                data_d  = m_data;
            end else if (valid_q && s_ready) begin
                valid_d = 1'b0;
            end
            if (flush_c) valid_d = 1'b0;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign s_valid = valid_q;
        assign s_data  = data_q;
        assign level   = {1'b0, valid_q};
    end else if (MODE == 1) begin : g_bwd
        logic             skid_valid_q, skid_valid_d;
        logic [WIDTH-1:0] skid_data_q, skid_data_d;
        logic             ready_q, ready_d;
        logic             accept_c;

        assign m_ready  = ready_q & ~block_c;
        assign accept_c = m_valid & m_ready;

        // Master passes straight through unless a beat is parked in the skid.
        assign s_valid = ~block_c & (skid_valid_q | m_valid);
        assign s_data  = rst ? '0 : (skid_valid_q ? skid_data_q : m_data);

        always_comb begin
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (s_ready) begin
                skid_valid_d = 1'b0;
            end else if (accept_c && !skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = m_data;
            end
            if (flush_c) skid_valid_d = 1'b0;
            ready_d = ~skid_valid_d;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                skid_valid_q <= 1'b0;
                skid_data_q  <= '0;
                ready_q      <= 1'b1;
            end else begin
                skid_valid_q <= skid_valid_d;
                skid_data_q  <= skid_data_d;
                ready_q      <= ready_d;
            end
        end

        assign level = {1'b0, skid_valid_q};
    end else begin : g_full
        typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} state_e;

        state_e           state_q, state_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             ready_q, ready_d;
        logic             valid_q, valid_d;
        logic [1:0]       level_q, level_d;
        logic             accept_c;
        logic             take_c;

        assign m_ready  = ready_q & ~block_c;
        assign accept_c = m_valid & m_ready;
        assign take_c   = valid_q & s_ready;

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_d = ST_BUSY;
                        main_d  = m_data;
                    end
                end
                ST_BUSY: begin
                    if (accept_c && take_c) begin
                        main_d = m_data;
                    end else if (take_c) begin
                        state_d = ST_EMPTY;
                    end else if (accept_c) begin
                        state_d = ST_FULL;
                        skid_d  = m_data;
                    end
                end
                ST_FULL: begin
                    if (take_c) begin
                        state_d = ST_BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
            if (flush_c) state_d = ST_EMPTY;

            // Outputs are decoded from the next state so they leave flops directly.
            ready_d = (state_d != ST_FULL);
            valid_d = (state_d != ST_EMPTY);
            level_d = (state_d == ST_FULL) ? 2'd2 : ((state_d == ST_BUSY) ? 2'd1 : 2'd0);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
                ready_q <= 1'b1;
                valid_q <= 1'b0;
                level_q <= 2'd0;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
                ready_q <= ready_d;
                valid_q <= valid_d;
                level_q <= level_d;
            end
        end

        assign s_valid = valid_q;
        assign s_data  = main_q;
        assign level   = level_q;
    end

endmodule
